// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared constants and types for the 16-to-4 priority encoder and its
// downstream capture stage.
//   CODE_W    : width of the encoder code L
//   N_SRC     : number of encoder request inputs
//   DEPTH_DEF : default capture FIFO depth
//   code_t    : one encoder code
// ---------------------------------------------------------------------------
package enc_pkg;
  localparam int CODE_W    = 4;
  localparam int N_SRC     = 16;
  localparam int DEPTH_DEF = 4;

  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/code_fifo.sv
// ---------------------------------------------------------------------------
// code_fifo
// Synchronous FIFO with a separate occupancy counter, so full and empty are
// never ambiguous even though the pointers wrap naturally.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write request (i_data)
//   i_pop      : read request; ignored while empty
//   o_data     : head entry, forced to zero while empty
//   o_valid    : FIFO non-empty
//   o_count    : occupancy, 0..DEPTH
//   o_drop     : a push was refused this cycle (full, no pop alongside)
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module code_fifo #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [CODE_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [CODE_W-1:0]          o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_drop  = i_push && w_full && !w_do_pop;
  assign o_valid = !w_empty;
  assign o_count = r_count;
  // Memory is not reset; masking keeps the head at zero while nothing is held.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/enc_code_capture.sv
// ---------------------------------------------------------------------------
// enc_code_capture
// Capture stage behind the 16-to-4 priority encoder. L/GS are registered
// every cycle; a new encode event (GS rising, or code change while GS high)
// pushes the sampled code into code_fifo. A consumer drains the FIFO with a
// valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   L, GS      : encoder code and group-select
//   EN         : capture enable (low suppresses pushes only)
//   CLR_OVF    : synchronous clear of OVF
//   CODE       : FIFO head code (zero while VALID low)
//   VALID      : FIFO non-empty
//   READY      : consumer ready
//   COUNT      : FIFO occupancy
//   OVF        : sticky, a push was dropped because the FIFO was full
// Handshake: a transfer happens on every rising edge where VALID && READY
// are both high; CODE/VALID only change after such a transfer or a push into
// an empty FIFO, so they hold steady while VALID && !READY.
// ---------------------------------------------------------------------------
module enc_code_capture #(
  parameter int DEPTH  = enc_pkg::DEPTH_DEF,
  parameter int CODE_W = enc_pkg::CODE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CODE_W-1:0]      L,
  input  logic                   GS,
  input  logic                   EN,
  input  logic                   CLR_OVF,
  output logic [CODE_W-1:0]      CODE,
  output logic                   VALID,
  input  logic                   READY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF
);
  import enc_pkg::*;

  logic [CODE_W-1:0] r_l_q;
  logic [CODE_W-1:0] r_l_p;
  logic              r_gs_q;
  logic              r_gs_p;
  logic              r_ovf;

  logic w_ev;
  logic w_pop;
  logic w_drop;

  // Sample and previous-sample registers run regardless of EN, so a code
  // held unchanged across an EN-low window does not look new afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l_q  <= '0;
      r_l_p  <= '0;
      r_gs_q <= 1'b0;
      r_gs_p <= 1'b0;
    end else begin
      r_l_q  <= L;
      r_gs_q <= GS;
      r_l_p  <= r_l_q;
      r_gs_p <= r_gs_q;
    end
  end

  assign w_ev  = EN && r_gs_q && (!r_gs_p || (r_l_q != r_l_p));
  assign w_pop = VALID && READY;

  code_fifo #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ev),
    .i_data  (r_l_q),
    .i_pop   (w_pop),
    .o_data  (CODE),
    .o_valid (VALID),
    .o_count (COUNT),
    .o_drop  (w_drop)
  );

  // A drop in the same cycle as CLR_OVF keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (CLR_OVF) begin
      r_ovf <= 1'b0;
    end
  end

  assign OVF = r_ovf;
endmodule

// File: tb/tb_enc_code_capture.sv
// ---------------------------------------------------------------------------
// tb_enc_code_capture
// Bench for enc_code_capture (DEPTH=4, CODE_W=4). Expected codes go into
// exp_q when the stimulus creates an encode event; tick() pops and compares
// whenever a VALID && READY transfer is about to happen on the next edge.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_enc_code_capture;
  localparam int DEPTH  = 4;
  localparam int CODE_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic [CODE_W-1:0]      L;
  logic                   GS;
  logic                   EN;
  logic                   CLR_OVF;
  logic [CODE_W-1:0]      CODE;
  logic                   VALID;
  logic                   READY;
  logic [$clog2(DEPTH):0] COUNT;
  logic                   OVF;

  logic [CODE_W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  enc_code_capture #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .L       (L),
    .GS      (GS),
    .EN      (EN),
    .CLR_OVF (CLR_OVF),
    .CODE    (CODE),
    .VALID   (VALID),
    .READY   (READY),
    .COUNT   (COUNT),
    .OVF     (OVF)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard side of the bench: if a transfer will occur on the coming
  // edge, compare the head code against the oldest expected code.
  task automatic tick();
    logic [CODE_W-1:0] e;
    if (rst_n && VALID && READY) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got code %0d, expected no transfer", CODE);
      end else begin
        e = exp_q.pop_front();
        if (CODE !== e) begin
          n_fail++;
          $display("FAIL pop_code: got %0d, expected %0d", CODE, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag);
    int budget;
    READY = 1'b1;
    budget = 40;
    while ((VALID || exp_q.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    READY = 1'b0;
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: VALID=%0b, %0d codes still expected", tag, VALID, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL %s_drain_count: got %0d, expected 0", tag, COUNT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; L = '0; GS = 1'b0; EN = 1'b1; CLR_OVF = 1'b0; READY = 1'b0;
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (VALID !== 1'b0 || COUNT !== 3'd0 || OVF !== 1'b0 || CODE !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_initial: VALID=%0b COUNT=%0d OVF=%0b CODE=%0d, expected all 0", VALID, COUNT, OVF, CODE);
    end
    rst_n = 1'b1;
    ticks(2);
    // queue three entries, then reset mid-stream
    GS = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      L = CODE_W'(i);
      tick();
    end
    GS = 1'b0;
    ticks(2);
    n_cmp++;
    if (COUNT !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_prefill_count: got %0d, expected 3", COUNT);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (VALID !== 1'b0 || COUNT !== 3'd0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: VALID=%0b COUNT=%0d OVF=%0b, expected 0 0 0", VALID, COUNT, OVF);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(4);
    n_cmp++;
    if (COUNT !== 3'd0 || VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: COUNT=%0d VALID=%0b, expected 0 0", COUNT, VALID);
    end
    // GS held high through reset release yields exactly one event
    GS = 1'b1; L = 4'd7;
    ticks(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(4'd7);
    ticks(5);
    n_cmp++;
    if (COUNT !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_gs_high_release: COUNT=%0d, expected 1", COUNT);
    end
    GS = 1'b0;
    drain("reset");
  endtask

  task automatic test_single();
    EN = 1'b1; READY = 1'b0; GS = 1'b0;
    ticks(2);
    GS = 1'b1; L = 4'd5;
    exp_q.push_back(4'd5);
    tick();
    n_cmp++;
    if (VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: VALID=%0b one edge after input, expected 0", VALID);
    end
    tick();
    n_cmp++;
    if (VALID !== 1'b1 || CODE !== 4'd5) begin
      n_fail++;
      $display("FAIL single_latency: VALID=%0b CODE=%0d, expected 1 5", VALID, CODE);
    end
    ticks(8);
    n_cmp++;
    if (COUNT !== 3'd1 || CODE !== 4'd5) begin
      n_fail++;
      $display("FAIL single_hold: COUNT=%0d CODE=%0d, expected 1 5", COUNT, CODE);
    end
    GS = 1'b0;
    drain("single");
  endtask

  task automatic test_walking();
    int max_cnt;
    max_cnt = 0;
    READY = 1'b1; GS = 1'b0;
    ticks(2);
    GS = 1'b1;
    for (int v = 0; v < 16; v++) begin
      L = CODE_W'(v);
      exp_q.push_back(CODE_W'(v));
      tick();
      if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
    end
    GS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
    end
    n_cmp++;
    if (max_cnt > 1) begin
      n_fail++;
      $display("FAIL walking_max_count: got %0d, expected at most 1", max_cnt);
    end
    drain("walking");
  endtask

  task automatic test_overflow();
    logic [CODE_W-1:0] codes[6];
    codes = '{4'd3, 4'd7, 4'd9, 4'd1, 4'd12, 4'd4};
    READY = 1'b0; GS = 1'b1;
    for (int i = 0; i < 6; i++) begin
      L = codes[i];
      if (i < DEPTH) exp_q.push_back(codes[i]);
      tick();
    end
    GS = 1'b0;
    ticks(2);
    n_cmp++;
    if (COUNT !== 3'd4 || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: COUNT=%0d OVF=%0b, expected 4 1", COUNT, OVF);
    end
    drain("overflow");
    n_cmp++;
    if (OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: OVF=%0b after drain, expected 1", OVF);
    end
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: OVF=%0b, expected 0", OVF);
    end
    // CLR_OVF in the same cycle as a dropped push: the drop wins
    GS = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      L = CODE_W'(i);
      if (i <= DEPTH) exp_q.push_back(CODE_W'(i));
      tick();
    end
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    n_cmp++;
    if (OVF !== 1'b1 || COUNT !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_vs_clear: OVF=%0b COUNT=%0d, expected 1 4", OVF, COUNT);
    end
    GS = 1'b0;
    tick();
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    drain("overflow2");
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear2: OVF=%0b, expected 0", OVF);
    end
  endtask

  task automatic test_full_push_pop();
    READY = 1'b0; GS = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      L = CODE_W'(2 * i);
      exp_q.push_back(CODE_W'(2 * i));
      tick();
    end
    GS = 1'b0;
    ticks(2);
    n_cmp++;
    if (COUNT !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpp_prefill: COUNT=%0d, expected 4", COUNT);
    end
    GS = 1'b1; L = 4'd10;
    exp_q.push_back(4'd10);
    tick();
    READY = 1'b1;
    tick();
    READY = 1'b0;
    n_cmp++;
    if (COUNT !== 3'd4 || OVF !== 1'b0 || CODE !== 4'd4) begin
      n_fail++;
      $display("FAIL fullpp_state: COUNT=%0d OVF=%0b CODE=%0d, expected 4 0 4", COUNT, OVF, CODE);
    end
    GS = 1'b0;
    tick();
    drain("fullpp");
  endtask

  task automatic test_enable();
    EN = 1'b0; READY = 1'b0; GS = 1'b1; L = 4'd3;
    ticks(2);
    L = 4'd8;
    ticks(3);
    n_cmp++;
    if (COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_blocked: COUNT=%0d, expected 0", COUNT);
    end
    EN = 1'b1;
    ticks(3);
    n_cmp++;
    if (COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_resume_nochange: COUNT=%0d, expected 0", COUNT);
    end
    L = 4'd9;
    exp_q.push_back(4'd9);
    ticks(3);
    n_cmp++;
    if (COUNT !== 3'd1 || CODE !== 4'd9) begin
      n_fail++;
      $display("FAIL enable_change: COUNT=%0d CODE=%0d, expected 1 9", COUNT, CODE);
    end
    GS = 1'b0;
    drain("enable");
  endtask

  task automatic test_random_codes();
    logic [CODE_W-1:0] prev;
    logic [CODE_W-1:0] v;
    READY = 1'b0; GS = 1'b1; EN = 1'b1;
    prev = L;
    for (int i = 0; i < 3; i++) begin
      v = CODE_W'($urandom_range(0, 15));
      if (v == prev) v = v + 4'd1;
      L = v;
      exp_q.push_back(v);
      prev = v;
      tick();
    end
    GS = 1'b0;
    ticks(2);
    n_cmp++;
    if (COUNT !== 3'd3) begin
      n_fail++;
      $display("FAIL random_count: COUNT=%0d, expected 3", COUNT);
    end
    drain("random");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_walking();
    test_overflow();
    test_full_push_pop();
    test_enable();
    test_random_codes();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d codes never delivered, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
